rs_station: RTL and testbench

Parametrised reservation station for the out-of-order core. It sits between dispatch (which supplies renamed operands) and the integer ALU. It holds up to RS_DEPTH arithmetic instructions and wakes operands from CDB_NUM parallel CDB channels. It dispatches one ready instruction per cycle through a valid/ready handshake. Unlike the previous station, it uses slot allocation with a free bitmap (no shifting), supports flush and output backpressure, and bypasses the CDB on insert.

---
 rtl/rs_station_pkg.sv | 65 ++++++
 rtl/rs_select.sv | 51 +++++
 rtl/rs_station.sv | 278 +++++++++++++++++++++++++++
 tb/tb_rs_station.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_station_pkg.sv
// rs_station_pkg: shared opcode encodings, ALU operation codes and the
// opcode-to-ALU decode helper used by the reservation station.
// Opcodes not listed in the decode map (branches, jumps, memory ops)
// fall through to an add, which is what the ALU uses for address math.
package rs_station_pkg;

    localparam int OPC_W    = 11;
    localparam int ALU_W    = 4;
    localparam int TAG_NONE = 0;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_LTHAN  = 4'd2,
        ALU_XOR    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_AND    = 4'd5,
        ALU_LSHIFT = 4'd6,
        ALU_RSHIFT = 4'd7
    } alu_op_e;

    localparam logic [OPC_W-1:0] OPC_LUI   = 11'd1;
    localparam logic [OPC_W-1:0] OPC_AUIPC = 11'd2;
    localparam logic [OPC_W-1:0] OPC_JAL   = 11'd3;
    localparam logic [OPC_W-1:0] OPC_JALR  = 11'd4;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 11'd5;
    localparam logic [OPC_W-1:0] OPC_LW    = 11'd6;
    localparam logic [OPC_W-1:0] OPC_SW    = 11'd7;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 11'd8;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 11'd9;
    localparam logic [OPC_W-1:0] OPC_SLTIU = 11'd10;
    localparam logic [OPC_W-1:0] OPC_XORI  = 11'd11;
    localparam logic [OPC_W-1:0] OPC_ORI   = 11'd12;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 11'd13;
    localparam logic [OPC_W-1:0] OPC_SLLI  = 11'd14;
    localparam logic [OPC_W-1:0] OPC_SRLI  = 11'd15;
    localparam logic [OPC_W-1:0] OPC_SRAI  = 11'd16;
    localparam logic [OPC_W-1:0] OPC_ADD   = 11'd17;
    localparam logic [OPC_W-1:0] OPC_SUB   = 11'd18;
    localparam logic [OPC_W-1:0] OPC_SLL   = 11'd19;
    localparam logic [OPC_W-1:0] OPC_SLT   = 11'd20;
    localparam logic [OPC_W-1:0] OPC_SLTU  = 11'd21;
    localparam logic [OPC_W-1:0] OPC_XOR   = 11'd22;
    localparam logic [OPC_W-1:0] OPC_SRL   = 11'd23;
    localparam logic [OPC_W-1:0] OPC_SRA   = 11'd24;
    localparam logic [OPC_W-1:0] OPC_OR    = 11'd25;
    localparam logic [OPC_W-1:0] OPC_AND   = 11'd26;

    function automatic alu_op_e decode_alu(input logic [OPC_W-1:0] opc);
        alu_op_e alu;
        case (opc)
            OPC_ADD, OPC_ADDI, OPC_AUIPC, OPC_LUI: alu = ALU_ADD;
            OPC_SUB:                               alu = ALU_SUB;
            OPC_SLT, OPC_SLTI, OPC_SLTU, OPC_SLTIU: alu = ALU_LTHAN;
            OPC_XOR, OPC_XORI:                     alu = ALU_XOR;
            OPC_OR, OPC_ORI:                       alu = ALU_OR;
            OPC_AND, OPC_ANDI:                     alu = ALU_AND;
            OPC_SLL, OPC_SLLI:                     alu = ALU_LSHIFT;
            OPC_SRL, OPC_SRLI, OPC_SRA, OPC_SRAI:  alu = ALU_RSHIFT;
            default:                               alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: combinational slot picker for the reservation station.
//   ready_i  : per-slot ready vector
//   age_i    : age matrix, row i bit j set when slot i is older than slot j
//              (only present when RS_AGE_SELECT_EN is defined)
//   grant_o  : one-hot grant of the chosen slot
//   found_o  : at least one slot is ready
// Build option: RS_AGE_SELECT_EN selects the oldest ready slot; otherwise
// the lowest-index ready slot wins.
module rs_select
    import rs_station_pkg::*;
#(
    parameter int RS_DEPTH = 16
) (
    input  logic [RS_DEPTH-1:0]               ready_i,
`ifdef RS_AGE_SELECT_EN
    input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_i,
`endif
    output logic [RS_DEPTH-1:0]               grant_o,
    output logic                              found_o
);

    logic [RS_DEPTH-1:0] cand_s;

`ifdef RS_AGE_SELECT_EN
    // A ready slot is a candidate only if it is older than every other ready slot.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            cand_s[i] = ready_i[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i) begin
                    cand_s[i] = cand_s[i] & (~ready_i[j] | age_i[i][j]);
                end else begin
                    cand_s[i] = cand_s[i];
                end
            end
        end
    end
`else
    // Without age tracking every ready slot is a candidate.
    always_comb begin
        cand_s = ready_i;
    end
`endif

    // Isolate the lowest set candidate bit (x & -x) so the grant is always one-hot.
    always_comb begin
        grant_o = cand_s & (~cand_s + {{(RS_DEPTH-1){1'b0}}, 1'b1});
        found_o = |ready_i;
    end

endmodule

// File: rtl/rs_station.sv
// rs_station: reservation station between dispatch and the integer ALU.
// Slots are allocated from a free bitmap (lowest free slot), operands are
// woken from CDB_NUM broadcast channels (lowest channel wins on duplicate
// tags, also bypassed on insert), and one ready slot per cycle is moved into
// a valid/ready output register with its opcode decoded to an ALU op.
// Ports: clk_in/rst_n_in (async active-low), rdy_in (global freeze),
//   flush_in, issue_* (dispatch handshake and operands), cdb_* (packed
//   broadcast channels), exe_* (ALU handshake and operands), count_out.
// Build option: RS_AGE_SELECT_EN adds an age matrix so select picks the
//   oldest ready slot instead of the lowest-index one.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int RS_DEPTH = 16,
    parameter int TAG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int CDB_NUM  = 3,
    parameter int OP_W     = 11,
    localparam int CNT_W   = $clog2(RS_DEPTH + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      issue_valid_in,
    output logic                      issue_ready_out,
    input  logic [TAG_W-1:0]          issue_tag_in,
    input  logic [OP_W-1:0]           issue_opcode_in,
    input  logic [TAG_W-1:0]          issue_qj_in,
    input  logic [TAG_W-1:0]          issue_qk_in,
    input  logic [DATA_W-1:0]         issue_vj_in,
    input  logic [DATA_W-1:0]         issue_vk_in,
    input  logic [CDB_NUM-1:0]        cdb_valid_in,
    input  logic [CDB_NUM*TAG_W-1:0]  cdb_tag_in,
    input  logic [CDB_NUM*DATA_W-1:0] cdb_value_in,
    output logic                      exe_valid_out,
    input  logic                      exe_ready_in,
    output logic [TAG_W-1:0]          exe_tag_out,
    output logic [3:0]                exe_alu_op_out,
    output logic [DATA_W-1:0]         exe_op1_out,
    output logic [DATA_W-1:0]         exe_op2_out,
    output logic [CNT_W-1:0]          count_out
);

    // Slot storage
    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [RS_DEPTH];
    logic [TAG_W-1:0]    tag_d [RS_DEPTH];
    logic [OP_W-1:0]     op_q  [RS_DEPTH];
    logic [OP_W-1:0]     op_d  [RS_DEPTH];
    logic [TAG_W-1:0]    qj_q  [RS_DEPTH];
    logic [TAG_W-1:0]    qj_d  [RS_DEPTH];
    logic [TAG_W-1:0]    qk_q  [RS_DEPTH];
    logic [TAG_W-1:0]    qk_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vj_q  [RS_DEPTH];
    logic [DATA_W-1:0]   vj_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_q  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_d  [RS_DEPTH];
    logic [CNT_W-1:0]    count_q, count_d;

    // Output register
    logic                exe_valid_q, exe_valid_d;
    logic [TAG_W-1:0]    exe_tag_q, exe_tag_d;
    logic [3:0]          exe_alu_q, exe_alu_d;
    logic [DATA_W-1:0]   exe_op1_q, exe_op1_d;
    logic [DATA_W-1:0]   exe_op2_q, exe_op2_d;

    // Control
    logic [RS_DEPTH-1:0] ready_s, free_s, free_oh_s, grant_s;
    logic                found_s, insert_s, load_s, pop_s;
    logic [TAG_W-1:0]    sel_tag_s;
    logic [OP_W-1:0]     sel_op_s;
    logic [DATA_W-1:0]   sel_vj_s, sel_vk_s;

`ifdef RS_AGE_SELECT_EN
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
`endif

    // Returns {hit, value}; scanning from the top channel down lets channel 0 win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [CDB_NUM-1:0]        vld,
        input logic [CDB_NUM*TAG_W-1:0]  tags,
        input logic [CDB_NUM*DATA_W-1:0] vals
    );
        logic [DATA_W:0] hit;
        hit = '0;
        for (int c = CDB_NUM - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag) && (tag != '0)) begin
                hit = {1'b1, vals[c*DATA_W +: DATA_W]};
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Ready vector, free-slot one-hot and handshake qualifiers.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_s[i] = valid_q[i] & (qj_q[i] == '0) & (qk_q[i] == '0);
        end
        free_s          = ~valid_q;
        free_oh_s       = free_s & (~free_s + {{(RS_DEPTH-1){1'b0}}, 1'b1});
        issue_ready_out = (count_q < CNT_W'(RS_DEPTH));
        insert_s        = issue_valid_in & issue_ready_out & ~flush_in;
        load_s          = ~exe_valid_q | exe_ready_in;
        pop_s           = load_s & found_s & ~flush_in;
    end

    rs_select #(
        .RS_DEPTH (RS_DEPTH)
    ) u_select (
        .ready_i (ready_s),
`ifdef RS_AGE_SELECT_EN
        .age_i   (age_q),
`endif
        .grant_o (grant_s),
        .found_o (found_s)
    );

    // One-hot mux of the granted slot's fields.
    always_comb begin
        sel_tag_s = '0;
        sel_op_s  = '0;
        sel_vj_s  = '0;
        sel_vk_s  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            sel_tag_s = sel_tag_s | ({TAG_W{grant_s[i]}}  & tag_q[i]);
            sel_op_s  = sel_op_s  | ({OP_W{grant_s[i]}}   & op_q[i]);
            sel_vj_s  = sel_vj_s  | ({DATA_W{grant_s[i]}} & vj_q[i]);
            sel_vk_s  = sel_vk_s  | ({DATA_W{grant_s[i]}} & vk_q[i]);
        end
    end

    // Next state: flush dominates; otherwise wakeup, insert with bypass, and select.
    always_comb begin : next_state
        logic [DATA_W:0] wj_s, wk_s, bj_s, bk_s;
        wj_s        = '0;
        wk_s        = '0;
        bj_s        = cdb_lookup(issue_qj_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
        bk_s        = cdb_lookup(issue_qk_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
        valid_d     = valid_q;
        count_d     = count_q;
        exe_valid_d = exe_valid_q;
        exe_tag_d   = exe_tag_q;
        exe_alu_d   = exe_alu_q;
        exe_op1_d   = exe_op1_q;
        exe_op2_d   = exe_op2_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            tag_d[i] = tag_q[i];
            op_d[i]  = op_q[i];
            qj_d[i]  = qj_q[i];
            qk_d[i]  = qk_q[i];
            vj_d[i]  = vj_q[i];
            vk_d[i]  = vk_q[i];
        end
        if (flush_in) begin
            valid_d     = '0;
            count_d     = '0;
            exe_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                wj_s = cdb_lookup(qj_q[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
                wk_s = cdb_lookup(qk_q[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
                qj_d[i] = (valid_q[i] && wj_s[DATA_W]) ? '0 : qj_q[i];
                vj_d[i] = (valid_q[i] && wj_s[DATA_W]) ? wj_s[DATA_W-1:0] : vj_q[i];
                qk_d[i] = (valid_q[i] && wk_s[DATA_W]) ? '0 : qk_q[i];
                vk_d[i] = (valid_q[i] && wk_s[DATA_W]) ? wk_s[DATA_W-1:0] : vk_q[i];
                if (insert_s && free_oh_s[i]) begin
                    tag_d[i] = issue_tag_in;
                    op_d[i]  = issue_opcode_in;
                    qj_d[i]  = bj_s[DATA_W] ? '0 : issue_qj_in;
                    vj_d[i]  = bj_s[DATA_W] ? bj_s[DATA_W-1:0] : issue_vj_in;
                    qk_d[i]  = bk_s[DATA_W] ? '0 : issue_qk_in;
                    vk_d[i]  = bk_s[DATA_W] ? bk_s[DATA_W-1:0] : issue_vk_in;
                end else begin
                    tag_d[i] = tag_q[i];
                    op_d[i]  = op_q[i];
                end
            end
            valid_d = (valid_q & ~(pop_s ? grant_s : '0)) | (insert_s ? free_oh_s : '0);
            count_d = count_q + CNT_W'(insert_s) - CNT_W'(pop_s);
            if (load_s) begin
                exe_valid_d = found_s;
                if (found_s) begin
                    exe_tag_d = sel_tag_s;
                    exe_alu_d = decode_alu(sel_op_s);
                    exe_op1_d = sel_vj_s;
                    exe_op2_d = sel_vk_s;
                end else begin
                    exe_tag_d = exe_tag_q;
                end
            end else begin
                exe_valid_d = exe_valid_q;
            end
        end
    end

`ifdef RS_AGE_SELECT_EN
    // A newly inserted slot is younger than every other slot: clear its row, set its column.
    always_comb begin
        age_d = age_q;
        if (flush_in) begin
            age_d = '0;
        end else begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                if (insert_s && free_oh_s[k]) begin
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        age_d[k][j] = 1'b0;
                        age_d[j][k] = (j != k);
                    end
                end else begin
                    age_d[k] = age_d[k];
                end
            end
        end
    end

    // Age matrix register, frozen with the rest of the state when rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            age_q <= '0;
        end else if (rdy_in) begin
            age_q <= age_d;
        end else begin
            age_q <= age_q;
        end
    end
`endif

    // Slot, counter and output registers; all updates gated by rdy_in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q     <= '0;
            count_q     <= '0;
            exe_valid_q <= 1'b0;
            exe_tag_q   <= '0;
            exe_alu_q   <= 4'd0;
            exe_op1_q   <= '0;
            exe_op2_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                tag_q[i] <= '0;
                op_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            exe_valid_q <= exe_valid_d;
            exe_tag_q   <= exe_tag_d;
            exe_alu_q   <= exe_alu_d;
            exe_op1_q   <= exe_op1_d;
            exe_op2_q   <= exe_op2_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
                op_q[i]  <= op_d[i];
                qj_q[i]  <= qj_d[i];
                qk_q[i]  <= qk_d[i];
                vj_q[i]  <= vj_d[i];
                vk_q[i]  <= vk_d[i];
            end
        end else begin
            valid_q <= valid_q;
        end
    end

    assign exe_valid_out  = exe_valid_q;
    assign exe_tag_out    = exe_tag_q;
    assign exe_alu_op_out = exe_alu_q;
    assign exe_op1_out    = exe_op1_q;
    assign exe_op2_out    = exe_op2_q;
    assign count_out      = count_q;

endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed testbench for rs_station with a slot-level
// behavioural model (sequence-number ages, first-match CDB search) that is
// stepped on every rising edge and compared against the DUT on every
// falling edge, plus hand-computed literal expectations.
module tb_rs_station;
    import rs_station_pkg::*;

    localparam int DEPTH = 16;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int CN    = 3;
    localparam int OW    = 11;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [TW-1:0]     issue_tag, issue_qj, issue_qk;
    logic [OW-1:0]     issue_op;
    logic [DW-1:0]     issue_vj, issue_vk;
    logic [CN-1:0]     cdb_valid;
    logic [CN*TW-1:0]  cdb_tag;
    logic [CN*DW-1:0]  cdb_value;
    logic              exe_valid, exe_ready;
    logic [TW-1:0]     exe_tag;
    logic [3:0]        exe_alu;
    logic [DW-1:0]     exe_op1, exe_op2;
    logic [CW-1:0]     count;

    rs_station #(.RS_DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW), .CDB_NUM(CN), .OP_W(OW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .issue_valid_in(issue_valid), .issue_ready_out(issue_ready),
        .issue_tag_in(issue_tag), .issue_opcode_in(issue_op),
        .issue_qj_in(issue_qj), .issue_qk_in(issue_qk),
        .issue_vj_in(issue_vj), .issue_vk_in(issue_vk),
        .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_value_in(cdb_value),
        .exe_valid_out(exe_valid), .exe_ready_in(exe_ready),
        .exe_tag_out(exe_tag), .exe_alu_op_out(exe_alu),
        .exe_op1_out(exe_op1), .exe_op2_out(exe_op2), .count_out(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit          m_v   [DEPTH];
    int          m_tag [DEPTH];
    int          m_op  [DEPTH];
    int          m_qj  [DEPTH];
    int          m_qk  [DEPTH];
    logic [31:0] m_vj  [DEPTH];
    logic [31:0] m_vk  [DEPTH];
    int          m_seq [DEPTH];
    int          seq_ctr;
    int          m_cnt;
    bit          e_v;
    int          e_tag, e_alu;
    logic [31:0] e_op1, e_op2;
    int          alu_map[int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int alu_of(input int op);
        if (alu_map.exists(op)) return alu_map[op];
        return int'(ALU_ADD);
    endfunction

    function automatic bit m_cdb(input int tag, output logic [31:0] val);
        val = '0;
        if (tag == 0) return 1'b0;
        for (int c = 0; c < CN; c++) begin
            if (cdb_valid[c] && (int'(cdb_tag[c*TW +: TW]) == tag)) begin
                val = cdb_value[c*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        m_cnt = 0; e_v = 1'b0; e_tag = 0; e_alu = 0; e_op1 = '0; e_op2 = '0; seq_ctr = 0;
    endtask

    task automatic model_step();
        int sel, fr;
        logic [31:0] v;
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            m_cnt = 0; e_v = 1'b0;
            return;
        end
        sel = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && m_qj[i] == 0 && m_qk[i] == 0) begin
`ifdef RS_AGE_SELECT_EN
                if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        fr = -1;
        if (issue_valid && m_cnt < DEPTH)
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fr = i;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && m_cdb(m_qj[i], v)) begin m_qj[i] = 0; m_vj[i] = v; end
            if (m_v[i] && m_cdb(m_qk[i], v)) begin m_qk[i] = 0; m_vk[i] = v; end
        end
        if (!e_v || exe_ready) begin
            if (sel >= 0) begin
                e_v = 1'b1; e_tag = m_tag[sel]; e_alu = alu_of(m_op[sel]);
                e_op1 = m_vj[sel]; e_op2 = m_vk[sel];
                m_v[sel] = 1'b0; m_cnt--;
            end else begin
                e_v = 1'b0;
            end
        end
        if (fr >= 0) begin
            m_v[fr] = 1'b1; m_tag[fr] = int'(issue_tag); m_op[fr] = int'(issue_op);
            m_qj[fr] = int'(issue_qj); m_vj[fr] = issue_vj;
            m_qk[fr] = int'(issue_qk); m_vk[fr] = issue_vk;
            if (m_cdb(m_qj[fr], v)) begin m_qj[fr] = 0; m_vj[fr] = v; end
            if (m_cdb(m_qk[fr], v)) begin m_qk[fr] = 0; m_vk[fr] = v; end
            m_seq[fr] = seq_ctr++; m_cnt++;
        end
    endtask

    task automatic compare_all();
        chk("exe_valid", exe_valid, e_v);
        chk("count", count, m_cnt);
        chk("issue_ready", issue_ready, (m_cnt < DEPTH));
        if (e_v) begin
            chk("exe_tag", exe_tag, e_tag);
            chk("exe_alu", exe_alu, e_alu);
            chk("exe_op1", exe_op1, e_op1);
            chk("exe_op2", exe_op2, e_op2);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        issue_valid = 1'b0; cdb_valid = '0; flush = 1'b0;
    endtask

    task automatic offer(input int tag, input logic [OW-1:0] op, input int qj,
                         input logic [31:0] vj, input int qk, input logic [31:0] vk);
        issue_valid = 1'b1; issue_tag = TW'(tag); issue_op = op;
        issue_qj = TW'(qj); issue_vj = vj; issue_qk = TW'(qk); issue_vk = vk;
    endtask

    task automatic set_cdb(input int ch, input int tag, input logic [31:0] val);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TW +: TW] = TW'(tag);
        cdb_value[ch*DW +: DW] = val;
    endtask

    logic [OW-1:0] ops [26] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BEQ, OPC_LW, OPC_SW,
        OPC_ADDI, OPC_SLTI, OPC_SLTIU, OPC_XORI, OPC_ORI, OPC_ANDI, OPC_SLLI, OPC_SRLI,
        OPC_SRAI, OPC_ADD, OPC_SUB, OPC_SLL, OPC_SLT, OPC_SLTU, OPC_XOR, OPC_SRL, OPC_SRA,
        OPC_OR, OPC_AND};

    initial begin
        int first_tag, second_tag;
        alu_map[int'(OPC_SUB)]  = int'(ALU_SUB);
        alu_map[int'(OPC_SLT)]  = int'(ALU_LTHAN);  alu_map[int'(OPC_SLTI)]  = int'(ALU_LTHAN);
        alu_map[int'(OPC_SLTU)] = int'(ALU_LTHAN);  alu_map[int'(OPC_SLTIU)] = int'(ALU_LTHAN);
        alu_map[int'(OPC_XOR)]  = int'(ALU_XOR);    alu_map[int'(OPC_XORI)]  = int'(ALU_XOR);
        alu_map[int'(OPC_OR)]   = int'(ALU_OR);     alu_map[int'(OPC_ORI)]   = int'(ALU_OR);
        alu_map[int'(OPC_AND)]  = int'(ALU_AND);    alu_map[int'(OPC_ANDI)]  = int'(ALU_AND);
        alu_map[int'(OPC_SLL)]  = int'(ALU_LSHIFT); alu_map[int'(OPC_SLLI)]  = int'(ALU_LSHIFT);
        alu_map[int'(OPC_SRL)]  = int'(ALU_RSHIFT); alu_map[int'(OPC_SRLI)]  = int'(ALU_RSHIFT);
        alu_map[int'(OPC_SRA)]  = int'(ALU_RSHIFT); alu_map[int'(OPC_SRAI)]  = int'(ALU_RSHIFT);

        rst_n = 1'b0; rdy = 1'b1; exe_ready = 1'b1;
        issue_tag = '0; issue_op = '0; issue_qj = '0; issue_qk = '0; issue_vj = '0; issue_vk = '0;
        cdb_tag = '0; cdb_value = '0;
        idle();
        model_reset();
        #12;
        chk("rst_exe_valid", exe_valid, 0);  chk("rst_exe_tag", exe_tag, 0);
        chk("rst_exe_alu", exe_alu, 0);      chk("rst_exe_op1", exe_op1, 0);
        chk("rst_exe_op2", exe_op2, 0);      chk("rst_count", count, 0);
        chk("rst_issue_ready", issue_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        cycle();

        // ADDI with both operands present dispatches one edge after insert
        offer(3, OPC_ADDI, 0, 32'd5, 0, 32'd7); cycle();
        idle(); cycle();
        chk("t1_valid", exe_valid, 1); chk("t1_tag", exe_tag, 3);
        chk("t1_alu", exe_alu, 0);     chk("t1_op1", exe_op1, 5); chk("t1_op2", exe_op2, 7);
        cycle();

        // Wakeup from CDB channel 2 one cycle after insert
        offer(4, OPC_ADD, 9, 32'd0, 0, 32'd1); cycle();
        idle(); set_cdb(2, 9, 32'h20); cycle();
        chk("t2_not_yet", exe_valid, 0);
        idle(); cycle();
        chk("t2_valid", exe_valid, 1); chk("t2_tag", exe_tag, 4); chk("t2_op1", exe_op1, 32'h20);
        cycle();

        // Insert bypass on qk from CDB channel 0
        offer(5, OPC_SUB, 0, 32'd3, 6, 32'd0); set_cdb(0, 6, 32'h11); cycle();
        idle(); cycle();
        chk("t3_valid", exe_valid, 1); chk("t3_alu", exe_alu, 1); chk("t3_op2", exe_op2, 32'h11);
        cycle();

        // Same tag on two channels: channel 1 beats channel 2
        offer(13, OPC_OR, 15, 32'd0, 15, 32'd0); cycle();
        idle(); set_cdb(1, 15, 32'hAA); set_cdb(2, 15, 32'hBB); cycle();
        idle(); cycle();
        chk("t4_op1", exe_op1, 32'hAA); chk("t4_op2", exe_op2, 32'hAA); chk("t4_alu", exe_alu, 4);
        cycle();

        // Opcode decode sweep, one ready instruction per cycle
        for (int i = 0; i < 26; i++) begin
            offer(i + 1, ops[i], 0, 32'(i), 0, 32'(i * 3)); cycle();
        end
        idle(); cycle(); cycle();

        // Fill all slots with blocked entries; the 17th offer is refused
        for (int k = 0; k < DEPTH + 1; k++) begin
            offer(k + 1, OPC_ADD, 20, 32'd0, 0, 32'd0); cycle();
        end
        chk("full_count", count, 16); chk("full_ready", issue_ready, 0);
        flush = 1'b1; cycle();
        idle(); cycle();
        chk("flush_count", count, 0); chk("flush_ready", issue_ready, 1); chk("flush_valid", exe_valid, 0);
        set_cdb(0, 20, 32'h5); cycle(); idle(); cycle();

        // Flush beats a simultaneous insert
        offer(9, OPC_ADD, 0, 32'd1, 0, 32'd1); flush = 1'b1; cycle();
        idle(); cycle();
        chk("flush_ins_count", count, 0);

        // Backpressure: output held, two ready slots wait
        exe_ready = 1'b0;
        offer(10, OPC_AND, 0, 32'd1, 0, 32'd2); cycle();
        offer(11, OPC_XOR, 0, 32'd3, 0, 32'd4); cycle();
        offer(12, OPC_SLL, 0, 32'd5, 0, 32'd6); cycle();
        idle();
        for (int h = 0; h < 5; h++) begin
            cycle();
            chk("hold_tag", exe_tag, 10); chk("hold_op1", exe_op1, 1); chk("hold_count", count, 2);
        end
`ifdef RS_AGE_SELECT_EN
        first_tag = 11; second_tag = 12;
`else
        first_tag = 12; second_tag = 11;
`endif
        exe_ready = 1'b1; cycle();
        chk("rel_first", exe_tag, first_tag);
        cycle();
        chk("rel_second", exe_tag, second_tag);
        cycle();
        chk("rel_empty", exe_valid, 0);

        // Freeze: rdy low ignores insert, CDB and the ALU handshake
        exe_ready = 1'b0;
        offer(21, OPC_ADD, 0, 32'd9, 0, 32'd9); cycle();
        offer(22, OPC_SUB, 7, 32'd0, 0, 32'd4); cycle();
        idle(); rdy = 1'b0; exe_ready = 1'b1;
        offer(23, OPC_ADD, 0, 32'd1, 0, 32'd1); set_cdb(0, 7, 32'h77);
        cycle(); cycle(); cycle();
        chk("frz_count", count, 1); chk("frz_tag", exe_tag, 21);
        idle(); rdy = 1'b1; cycle();
        set_cdb(1, 7, 32'h70); cycle();
        idle(); cycle();
        chk("frz_wake_op1", exe_op1, 32'h70);
        cycle();

        // Blocked A then ready B, then wake A: B goes first
        offer(24, OPC_ADD, 8, 32'd0, 0, 32'd0); cycle();
        offer(25, OPC_ADD, 0, 32'd2, 0, 32'd2); cycle();
        idle(); set_cdb(0, 8, 32'h8); cycle();
        chk("age_b", exe_tag, 25);
        idle(); cycle();
        chk("age_a", exe_tag, 24);
        cycle();

        // Asynchronous reset mid-operation
        exe_ready = 1'b0;
        offer(26, OPC_ADD, 0, 32'd3, 0, 32'd3); cycle();
        offer(27, OPC_ADD, 3, 32'd0, 0, 32'd3); cycle();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", exe_valid, 0); chk("arst_count", count, 0);
        chk("arst_tag", exe_tag, 0);     chk("arst_ready", issue_ready, 1);
        model_reset();
        @(negedge clk); rst_n = 1'b1; exe_ready = 1'b1;
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
